encap_pio_mem_ctrl: RTL and testbench

Per-memory PIO access controller sitting directly downstream of the encap PIO decoder. One instance fronts each encap table memory: tunnel hash table, tunnel value, ekey hash table and ekey value. Each instance arbitrates between the PIO register path and the datapath lookup port for a single-port synchronous RAM. It returns `mem_ack` and read data to the decoder with timing compatible with the decoder's `clk_div`-qualified sampling.

---
 rtl/encap_pio_mem_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_encap_pio_mem_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/encap_pio_mem_ctrl.sv
// encap_pio_mem_ctrl
// ------------------
// Arbitrates one single-port synchronous RAM (1-cycle read latency) between the
// encap PIO decoder and a datapath lookup port. One instance per encap table
// memory (tunnel hash, tunnel value, ekey hash, ekey value).
//
// Optional feature: define ENCAP_PIO_STARVE_GUARD_EN to add a 4-bit starvation
// counter. When enabled, a PIO request that has been blocked by lu_req for
// STARVE_LIMIT consecutive PEND cycles is forced onto the RAM on the next PEND
// cycle. When disabled, a PIO request waits for as long as lu_req stays high.
//
// Ports:
//   clk, rst_n           core clock, asynchronous active-low reset
//   clk_div              single-cycle decoder sampling strobe
//   reg_ms               memory select for this instance
//   reg_rd, reg_wr       one-clk PIO command pulses (both high = write)
//   reg_addr, reg_din    PIO address (low ADDR_NBITS used) and write data
//   lu_req, lu_addr      lookup request (held until granted) and address
//   lu_gnt               lookup granted this cycle
//   lu_valid, lu_rdata   lookup read data, one cycle after the grant
//   ram_en, ram_wr,
//   ram_addr, ram_wdata  RAM strobes, combinational, registered by the RAM
//   ram_rdata            RAM read data
//   mem_ack, mem_rdata   PIO completion and last PIO read data
//   pio_err              sticky: a command arrived while busy (dropped)
//   fsm_state            debug view of the controller state
//
// Handshakes: lu_req/lu_gnt is valid/ready -- a lookup is consumed on the cycle
// both are high, and lu_req must stay high (address stable) until then.
// A PIO command is accepted only in IDLE. mem_ack stays high from
// completion through the first clk_div cycle seen in DONE.

`ifndef PIO_NBITS
`define PIO_NBITS 32
`endif

module encap_pio_mem_ctrl #(
  parameter int ADDR_NBITS   = 10,
  parameter int DATA_NBITS   = `PIO_NBITS,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clk_div,
  input  logic                   reg_ms,
  input  logic                   reg_rd,
  input  logic                   reg_wr,
  input  logic [`PIO_NBITS-1:0]  reg_addr,
  input  logic [`PIO_NBITS-1:0]  reg_din,
  input  logic                   lu_req,
  input  logic [ADDR_NBITS-1:0]  lu_addr,
  output logic                   lu_gnt,
  output logic                   lu_valid,
  output logic [DATA_NBITS-1:0]  lu_rdata,
  output logic                   ram_en,
  output logic                   ram_wr,
  output logic [ADDR_NBITS-1:0]  ram_addr,
  output logic [DATA_NBITS-1:0]  ram_wdata,
  input  logic [DATA_NBITS-1:0]  ram_rdata,
  output logic                   mem_ack,
  output logic [`PIO_NBITS-1:0]  mem_rdata,
  output logic                   pio_err,
  output logic [1:0]             fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    RDWAIT = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t                  state_q, state_d;
  logic                    op_wr_q;
  logic [ADDR_NBITS-1:0]   pio_addr_q;
  logic [DATA_NBITS-1:0]   pio_data_q;
  logic                    cmd;
  logic                    pio_force;
  logic                    pio_issue;

  assign cmd       = reg_ms & (reg_rd | reg_wr);
  assign pio_issue = (state_q == PEND) & (~lu_req | pio_force);
  assign fsm_state = state_q;
  assign mem_ack   = (state_q == DONE);

`ifdef ENCAP_PIO_STARVE_GUARD_EN
  logic [3:0] starve_q;

  // Counts PEND cycles lost to lookups; saturates at the limit because the
  // forced access clears it on that same cycle.
  assign pio_force = (starve_q >= STARVE_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= 4'd0;
    end else if (pio_issue) begin
      starve_q <= 4'd0;
    end else if ((state_q == PEND) && lu_req) begin
      starve_q <= starve_q + 4'd1;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{reg_addr[`PIO_NBITS-1:ADDR_NBITS]};
`else
  assign pio_force = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{reg_addr[`PIO_NBITS-1:ADDR_NBITS], STARVE_MAX};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lu_gnt    = 1'b0;
    ram_en    = 1'b0;
    ram_wr    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;

    case (state_q)
      IDLE:    if (cmd) state_d = PEND;
      PEND:    if (pio_issue) state_d = op_wr_q ? DONE : RDWAIT;
      RDWAIT:  state_d = DONE;
      DONE:    if (clk_div) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // pio_issue is only ever high in PEND, so everywhere else this reduces
    // to lu_gnt = lu_req. Gated by rst_n so the grant is quiet during reset.
    lu_gnt = rst_n & lu_req & ~pio_issue;

    if (pio_issue) begin
      ram_en    = 1'b1;
      ram_wr    = op_wr_q;
      ram_addr  = pio_addr_q;
      ram_wdata = pio_data_q;
    end else if (lu_gnt) begin
      ram_en   = 1'b1;
      ram_addr = lu_addr;
    end
  end

  // Command capture; a write wins when rd and wr arrive together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_wr_q    <= 1'b0;
      pio_addr_q <= '0;
      pio_data_q <= '0;
    end else if ((state_q == IDLE) && cmd) begin
      op_wr_q    <= reg_wr;
      pio_addr_q <= reg_addr[ADDR_NBITS-1:0];
      pio_data_q <= reg_din[DATA_NBITS-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pio_err <= 1'b0;
    end else if (cmd && (state_q != IDLE)) begin
      pio_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rdata <= '0;
    end else if (state_q == RDWAIT) begin
      mem_rdata <= ram_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_valid <= 1'b0;
    end else begin
      lu_valid <= lu_gnt;
    end
  end

  // The RAM returns the lookup word in the cycle lu_valid is high; pass it
  // through and keep the bus at zero otherwise.
  assign lu_rdata = lu_valid ? ram_rdata : '0;

endmodule

// File: tb/tb_encap_pio_mem_ctrl.sv
// Directed bench for encap_pio_mem_ctrl with a behavioural single-port RAM.
module tb_encap_pio_mem_ctrl;

  localparam int          LIMIT     = 8;
  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_PEND   = 2'd1;
  localparam logic [1:0]  ST_RDWAIT = 2'd2;

  logic        clk;
  logic        rst_n;
  logic        clk_div;
  logic        reg_ms;
  logic        reg_rd;
  logic        reg_wr;
  logic [31:0] reg_addr;
  logic [31:0] reg_din;
  logic        lu_req;
  logic [9:0]  lu_addr;
  logic        lu_gnt;
  logic        lu_valid;
  logic [31:0] lu_rdata;
  logic        ram_en;
  logic        ram_wr;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        pio_err;
  logic [1:0]  fsm_state;

  int n_vec = 0;
  int n_err = 0;

  encap_pio_mem_ctrl #(
    .ADDR_NBITS  (10),
    .DATA_NBITS  (32),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_div  (clk_div),
    .reg_ms   (reg_ms),
    .reg_rd   (reg_rd),
    .reg_wr   (reg_wr),
    .reg_addr (reg_addr),
    .reg_din  (reg_din),
    .lu_req   (lu_req),
    .lu_addr  (lu_addr),
    .lu_gnt   (lu_gnt),
    .lu_valid (lu_valid),
    .lu_rdata (lu_rdata),
    .ram_en   (ram_en),
    .ram_wr   (ram_wr),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .pio_err  (pio_err),
    .fsm_state(fsm_state)
  );

  // clock / RAM fixture
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] ram [0:1023];
  initial ram_rdata = 32'h0;
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wr) ram[ram_addr] <= ram_wdata;
      ram_rdata <= ram[ram_addr];
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pio_write(input logic [31:0] a, input logic [31:0] d);
    cyc(); reg_ms = 1'b1; reg_wr = 1'b1; reg_addr = a; reg_din = d;
    cyc(); reg_ms = 1'b0; reg_wr = 1'b0;
    cyc(); clk_div = 1'b1;
    cyc(); clk_div = 1'b0;
  endtask

  task automatic pio_read_cmd(input logic [31:0] a);
    cyc(); reg_ms = 1'b1; reg_rd = 1'b1; reg_addr = a;
    cyc(); reg_ms = 1'b0; reg_rd = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    @(negedge clk);
    n_vec++;
    if ({ram_en, ram_wr, lu_gnt, lu_valid, mem_ack, pio_err} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {ram_en, ram_wr, lu_gnt, lu_valid, mem_ack, pio_err});
    end
    n_vec++;
    if ({mem_rdata, lu_rdata, ram_wdata, ram_addr} !== 106'h0) begin
      n_err++;
      $display("FAIL reset_data: mem_rdata=%h lu_rdata=%h ram_wdata=%h ram_addr=%h want 0",
               mem_rdata, lu_rdata, ram_wdata, ram_addr);
    end
    n_vec++;
    if (fsm_state !== ST_IDLE) begin
      n_err++; $display("FAIL reset_state: got %0d want 0", fsm_state);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    cyc(); reg_ms = 1'b1; reg_wr = 1'b1; reg_addr = 32'h5; reg_din = 32'hDEADBEEF;
    @(negedge clk);
    n_vec++;
    if (ram_en !== 1'b0) begin n_err++; $display("FAIL wr_c0_en: got %b want 0", ram_en); end
    cyc(); reg_ms = 1'b0; reg_wr = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({ram_en, ram_wr, ram_addr, ram_wdata} !== {2'b11, 10'h5, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL wr_c1_ram: got en=%b wr=%b a=%h d=%h want 1 1 005 deadbeef",
               ram_en, ram_wr, ram_addr, ram_wdata);
    end
    cyc(); @(negedge clk);
    n_vec++;
    if (mem_ack !== 1'b1 || ram_en !== 1'b0) begin
      n_err++; $display("FAIL wr_c2_ack: got ack=%b en=%b want 1 0", mem_ack, ram_en);
    end
    cyc(); clk_div = 1'b1; @(negedge clk);
    n_vec++;
    if (mem_ack !== 1'b1) begin n_err++; $display("FAIL wr_c3_hold: got %b want 1", mem_ack); end
    cyc(); clk_div = 1'b0; @(negedge clk);
    n_vec++;
    if (mem_ack !== 1'b0 || fsm_state !== ST_IDLE) begin
      n_err++; $display("FAIL wr_c4_drop: got ack=%b st=%0d want 0 0", mem_ack, fsm_state);
    end
    // read back
    pio_read_cmd(32'h5);
    @(negedge clk);
    n_vec++;
    if ({ram_en, ram_wr, ram_addr} !== {2'b10, 10'h5}) begin
      n_err++; $display("FAIL rd_c1_ram: got en=%b wr=%b a=%h want 1 0 005", ram_en, ram_wr, ram_addr);
    end
    cyc(); @(negedge clk);
    n_vec++;
    if (mem_ack !== 1'b0) begin n_err++; $display("FAIL rd_c2_ack: got %b want 0", mem_ack); end
    cyc(); clk_div = 1'b1; @(negedge clk);
    n_vec++;
    if (mem_ack !== 1'b1 || mem_rdata !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL rd_c3: got ack=%b data=%h want 1 deadbeef", mem_ack, mem_rdata);
    end
    cyc(); clk_div = 1'b0;
  endtask

  task automatic test_lu_priority();
    pio_read_cmd(32'h3);
    lu_req = 1'b1; lu_addr = 10'h1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_vec++;
      if (lu_gnt !== 1'b1 || ram_addr !== 10'h1 || ram_wr !== 1'b0 || fsm_state !== ST_PEND) begin
        n_err++;
        $display("FAIL lupri_c%0d: got gnt=%b a=%h wr=%b st=%0d want 1 001 0 1",
                 k, lu_gnt, ram_addr, ram_wr, fsm_state);
      end
      if (k == 2) begin
        n_vec++;
        if (lu_valid !== 1'b1 || lu_rdata !== 32'h11110001) begin
          n_err++; $display("FAIL lupri_luv: got v=%b d=%h want 1 11110001", lu_valid, lu_rdata);
        end
      end
      cyc();
    end
    lu_req = 1'b0;
    @(negedge clk);
    n_vec++;
    if (lu_gnt !== 1'b0 || ram_en !== 1'b1 || ram_addr !== 10'h3) begin
      n_err++; $display("FAIL lupri_c4: got gnt=%b en=%b a=%h want 0 1 003", lu_gnt, ram_en, ram_addr);
    end
    cyc(); @(negedge clk);
    n_vec++;
    if (mem_ack !== 1'b0) begin n_err++; $display("FAIL lupri_c5: got ack=%b want 0", mem_ack); end
    cyc(); clk_div = 1'b1; @(negedge clk);
    n_vec++;
    if (mem_ack !== 1'b1 || mem_rdata !== 32'h33330003) begin
      n_err++; $display("FAIL lupri_c6: got ack=%b d=%h want 1 33330003", mem_ack, mem_rdata);
    end
    cyc(); clk_div = 1'b0;
  endtask

  task automatic test_busy_err();
    pio_read_cmd(32'h1);
    cyc();
    cyc(); reg_ms = 1'b1; reg_rd = 1'b1; reg_addr = 32'h2;
    @(negedge clk);
    n_vec++;
    if (mem_ack !== 1'b1 || pio_err !== 1'b0) begin
      n_err++; $display("FAIL busy_c3: got ack=%b err=%b want 1 0", mem_ack, pio_err);
    end
    cyc(); reg_ms = 1'b0; reg_rd = 1'b0; clk_div = 1'b1;
    @(negedge clk);
    n_vec++;
    if (pio_err !== 1'b1 || mem_ack !== 1'b1 || mem_rdata !== 32'h11110001) begin
      n_err++;
      $display("FAIL busy_c4: got err=%b ack=%b d=%h want 1 1 11110001", pio_err, mem_ack, mem_rdata);
    end
    for (int k = 0; k < 2; k++) begin
      cyc(); clk_div = 1'b0; @(negedge clk);
      n_vec++;
      if (fsm_state !== ST_IDLE || ram_en !== 1'b0 || pio_err !== 1'b1) begin
        n_err++;
        $display("FAIL busy_after%0d: got st=%0d en=%b err=%b want 0 0 1", k, fsm_state, ram_en, pio_err);
      end
    end
  endtask

  task automatic test_back_to_back();
    pio_read_cmd(32'h2);
    cyc(); lu_req = 1'b1; lu_addr = 10'h1;
    @(negedge clk);
    n_vec++;
    if (lu_gnt !== 1'b1 || ram_addr !== 10'h1 || fsm_state !== ST_RDWAIT) begin
      n_err++; $display("FAIL b2b_c2: got gnt=%b a=%h st=%0d want 1 001 2", lu_gnt, ram_addr, fsm_state);
    end
    cyc(); lu_addr = 10'h2;
    @(negedge clk);
    n_vec++;
    if (lu_gnt !== 1'b1 || lu_valid !== 1'b1 || lu_rdata !== 32'h11110001 ||
        mem_rdata !== 32'h22220002 || mem_ack !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_c3: got gnt=%b v=%b lu=%h mem=%h ack=%b want 1 1 11110001 22220002 1",
               lu_gnt, lu_valid, lu_rdata, mem_rdata, mem_ack);
    end
    cyc(); lu_req = 1'b0; clk_div = 1'b1;
    @(negedge clk);
    n_vec++;
    if (lu_valid !== 1'b1 || lu_rdata !== 32'h22220002 || mem_rdata !== 32'h22220002) begin
      n_err++;
      $display("FAIL b2b_c4: got v=%b lu=%h mem=%h want 1 22220002 22220002", lu_valid, lu_rdata, mem_rdata);
    end
    cyc(); clk_div = 1'b0;
    @(negedge clk);
    n_vec++;
    if (lu_valid !== 1'b0 || lu_rdata !== 32'h0) begin
      n_err++; $display("FAIL b2b_c5: got v=%b lu=%h want 0 0", lu_valid, lu_rdata);
    end
  endtask

  task automatic test_starve();
    cyc(); reg_ms = 1'b1; reg_wr = 1'b1; reg_addr = 32'h9; reg_din = 32'h00000999;
    lu_req = 1'b1; lu_addr = 10'h3;
    cyc(); reg_ms = 1'b0; reg_wr = 1'b0;
`ifdef ENCAP_PIO_STARVE_GUARD_EN
    for (int k = 1; k <= LIMIT; k++) begin
      @(negedge clk);
      n_vec++;
      if (lu_gnt !== 1'b1 || ram_wr !== 1'b0) begin
        n_err++; $display("FAIL starve_blk%0d: got gnt=%b wr=%b want 1 0", k, lu_gnt, ram_wr);
      end
      cyc();
    end
`else
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      n_vec++;
      if (lu_gnt !== 1'b1 || ram_wr !== 1'b0 || fsm_state !== ST_PEND) begin
        n_err++;
        $display("FAIL starve_wait%0d: got gnt=%b wr=%b st=%0d want 1 0 1", k, lu_gnt, ram_wr, fsm_state);
      end
      cyc();
    end
    lu_req = 1'b0;
`endif
    @(negedge clk);
    n_vec++;
    if (lu_gnt !== 1'b0 || ram_wr !== 1'b1 || ram_addr !== 10'h9 || ram_wdata !== 32'h00000999) begin
      n_err++;
      $display("FAIL starve_issue: got gnt=%b wr=%b a=%h d=%h want 0 1 009 00000999",
               lu_gnt, ram_wr, ram_addr, ram_wdata);
    end
    cyc(); @(negedge clk);
    n_vec++;
    if (mem_ack !== 1'b1) begin n_err++; $display("FAIL starve_ack: got %b want 1", mem_ack); end
    lu_req = 1'b0; clk_div = 1'b1;
    cyc(); clk_div = 1'b0;
  endtask

  task automatic test_async_reset();
    pio_read_cmd(32'h3);
    cyc(); lu_req = 1'b1; lu_addr = 10'h2;
    @(negedge clk);
    n_vec++;
    if (fsm_state !== ST_RDWAIT || ram_en !== 1'b1) begin
      n_err++; $display("FAIL arst_pre: got st=%0d en=%b want 2 1", fsm_state, ram_en);
    end
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({ram_en, ram_wr, lu_gnt, lu_valid, mem_ack, pio_err} !== 6'b0 || fsm_state !== ST_IDLE) begin
      n_err++;
      $display("FAIL arst_ctrl: got %b st=%0d want 000000 0",
               {ram_en, ram_wr, lu_gnt, lu_valid, mem_ack, pio_err}, fsm_state);
    end
    n_vec++;
    if ({mem_rdata, lu_rdata, ram_addr, ram_wdata} !== 106'h0) begin
      n_err++; $display("FAIL arst_data: got mem=%h lu=%h a=%h d=%h want 0", mem_rdata, lu_rdata, ram_addr, ram_wdata);
    end
    lu_req = 1'b0;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    cyc(); @(negedge clk);
    n_vec++;
    if (fsm_state !== ST_IDLE || mem_ack !== 1'b0 || pio_err !== 1'b0) begin
      n_err++; $display("FAIL arst_post: got st=%0d ack=%b err=%b want 0 0 0", fsm_state, mem_ack, pio_err);
    end
  endtask

  initial begin
    rst_n = 1'b1; clk_div = 1'b0; reg_ms = 1'b0; reg_rd = 1'b0; reg_wr = 1'b0;
    reg_addr = 32'h0; reg_din = 32'h0; lu_req = 1'b0; lu_addr = 10'h0;
    #2 rst_n = 1'b0;
    test_reset();
    test_write_read();
    pio_write(32'h1, 32'h11110001);
    pio_write(32'h2, 32'h22220002);
    pio_write(32'h3, 32'h33330003);
    test_lu_priority();
    test_busy_err();
    test_back_to_back();
    test_starve();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
